// File: rtl/ddr_dqs_eye_train_pkg.sv
// Shared types for the DQS eye-training slice: FSM state encoding, the
// centering sub-phase, the 8-bit tap type and the eye arithmetic helpers.
package ddr_dqs_eye_train_pkg;

  localparam int TAP_W = 8;

  typedef logic [TAP_W-1:0] tap_t;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    CLEAR  = 4'd2,
    SETTLE = 4'd3,
    SAMPLE = 4'd4,
    EVAL   = 4'd5,
    STEP   = 4'd6,
    CENTER = 4'd7,
    DONE   = 4'd8,
    ERR    = 4'd9
  } train_state_e;

  // CENTER runs as: width check, then alternating move / gap cycles.
  typedef enum logic [1:0] {
    CPH_CHECK = 2'd0,
    CPH_MOVE  = 2'd1,
    CPH_GAP   = 2'd2
  } center_phase_e;

  // Midpoint of the recorded eye, computed one bit wider so the sum never wraps.
  function automatic tap_t center_tap(input tap_t left, input tap_t right);
    logic [TAP_W:0] sum;
    sum = {1'b0, left} + {1'b0, right};
    return sum[TAP_W:1];
  endfunction

  // True when the inclusive eye width right-left+1 is below the minimum.
  function automatic logic eye_too_narrow(input tap_t left, input tap_t right,
                                          input int min_eye);
    int width;
    width = int'(right) - int'(left) + 32'sd1;
    return (width < min_eye);
  endfunction

endpackage

// File: rtl/ddr_dqs_eye_train_if.sv
// Lane-side bundle between the trainer and one DQS lane: delay-line controls
// and eye-monitor flags. master = trainer, slave = lane.
interface ddr_dqs_eye_train_if;

  logic EYE_MONITOR_EARLY;
  logic EYE_MONITOR_LATE;
  logic DELAY_LINE_OUT_OF_RANGE;
  logic DELAY_LINE_LOAD;
  logic DELAY_LINE_MOVE;
  logic DELAY_LINE_DIRECTION;
  logic EYE_MONITOR_CLEAR_FLAGS;

  modport master (
    input  EYE_MONITOR_EARLY,
    input  EYE_MONITOR_LATE,
    input  DELAY_LINE_OUT_OF_RANGE,
    output DELAY_LINE_LOAD,
    output DELAY_LINE_MOVE,
    output DELAY_LINE_DIRECTION,
    output EYE_MONITOR_CLEAR_FLAGS
  );

  modport slave (
    output EYE_MONITOR_EARLY,
    output EYE_MONITOR_LATE,
    output DELAY_LINE_OUT_OF_RANGE,
    input  DELAY_LINE_LOAD,
    input  DELAY_LINE_MOVE,
    input  DELAY_LINE_DIRECTION,
    input  EYE_MONITOR_CLEAR_FLAGS
  );

endinterface

// File: rtl/ddr_dqs_eye_sampler.sv
// Settle/sample timer for the eye trainer. While settle_en is high it counts
// SETTLE_CYC cycles; while sample_en is high it counts SAMPLE_CYC cycles and
// ORs the eye-monitor flags. pass is valid in the sample_done cycle.
module ddr_dqs_eye_sampler #(
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic settle_en,
  input  logic sample_en,
  input  logic early,
  input  logic late,
  output logic settle_done,
  output logic sample_done,
  output logic pass
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SAMPLE_LAST = 16'(SAMPLE_CYC - 1);

  logic [15:0] cnt_r;
  logic        fail_r;
  logic        hit_s;

  assign hit_s       = early | late;
  assign settle_done = settle_en & (cnt_r == SETTLE_LAST);
  assign sample_done = sample_en & (cnt_r == SAMPLE_LAST);
  // The last window cycle is folded in directly so no flag is missed.
  assign pass        = ~(fail_r | hit_s);

  // Window counter: restarts at each phase end and whenever idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (settle_done || sample_done) begin
      cnt_r <= 16'd0;
    end else if (settle_en || sample_en) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= 16'd0;
    end
  end

  // Sticky fail accumulator over the sample window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_r <= 1'b0;
    end else if (sample_en && !sample_done) begin
      fail_r <= fail_r | hit_s;
    end else begin
      fail_r <= 1'b0;
    end
  end

endmodule

// File: rtl/ddr_dqs_eye_train.sv
// DQS eye trainer: scans the lane delay line upward from tap 0, finds the
// first passing window, then walks back to its centre.
// Control pulses are registered and appear the cycle after the FSM decides
// them. Optional macro DQS_TRAIN_STATUS_EN exposes the recorded eye edges
// on EYE_LEFT / EYE_RIGHT.
module ddr_dqs_eye_train
  import ddr_dqs_eye_train_pkg::*;
#(
  parameter int TAP_MAX    = 127,
  parameter int SETTLE_CYC = 8,
  parameter int SAMPLE_CYC = 16,
  parameter int MIN_EYE    = 4
) (
  input  logic                      FAB_CLK,
  input  logic                      ARST_N,
  input  logic                      TRAIN_START,
  ddr_dqs_eye_train_if.master       lane,
  output logic [TAP_W-1:0]          TAP_COUNT,
  output logic                      TRAIN_DONE,
  output logic                      TRAIN_ERR
`ifdef DQS_TRAIN_STATUS_EN
  ,
  output logic [TAP_W-1:0]          EYE_LEFT,
  output logic [TAP_W-1:0]          EYE_RIGHT
`endif
);

  localparam tap_t TAP_LAST = tap_t'(TAP_MAX);

  train_state_e  state_r, state_n;
  center_phase_e cph_r, cph_n;
  tap_t          tap_r, tap_n;
  tap_t          left_r, left_n;
  tap_t          right_r, right_n;
  tap_t          target_r, target_n;
  logic          open_r, open_n;
  logic          pass_r, pass_n;
  logic          fin_r, fin_n;
  logic          load_r, load_n;
  logic          move_r, move_n;
  logic          clr_r, clr_n;
  logic          dir_r, dir_n;
  logic          done_r, done_n;
  logic          err_r, err_n;

  logic          settle_done_s;
  logic          sample_done_s;
  logic          pass_s;

  ddr_dqs_eye_sampler #(
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLE_CYC (SAMPLE_CYC)
  ) u_sampler (
    .clk         (FAB_CLK),
    .rst_n       (ARST_N),
    .settle_en   (state_r == SETTLE),
    .sample_en   (state_r == SAMPLE),
    .early       (lane.EYE_MONITOR_EARLY),
    .late        (lane.EYE_MONITOR_LATE),
    .settle_done (settle_done_s),
    .sample_done (sample_done_s),
    .pass        (pass_s)
  );

  // Next-state and next-output decode for the training sequence.
  always_comb begin
    state_n  = state_r;
    cph_n    = cph_r;
    tap_n    = tap_r;
    left_n   = left_r;
    right_n  = right_r;
    target_n = target_r;
    open_n   = open_r;
    pass_n   = pass_r;
    fin_n    = fin_r;
    dir_n    = dir_r;
    load_n   = 1'b0;
    move_n   = 1'b0;
    clr_n    = 1'b0;

    case (state_r)
      IDLE, DONE, ERR: begin
        if (TRAIN_START) begin
          // Direction goes up here so it is stable long before the first move.
          state_n = LOAD;
          tap_n   = 8'd0;
          dir_n   = 1'b1;
          load_n  = 1'b1;
        end else begin
          state_n = state_r;
        end
      end
      LOAD: begin
        open_n  = 1'b0;
        fin_n   = 1'b0;
        state_n = CLEAR;
      end
      CLEAR: begin
        clr_n   = 1'b1;
        state_n = SETTLE;
      end
      SETTLE: begin
        if (settle_done_s) begin
          state_n = fin_r ? DONE : SAMPLE;
        end else begin
          state_n = SETTLE;
        end
      end
      SAMPLE: begin
        if (sample_done_s) begin
          pass_n  = pass_s;
          state_n = EVAL;
        end else begin
          state_n = SAMPLE;
        end
      end
      EVAL: begin
        if (pass_r) begin
          if (!open_r) begin
            open_n = 1'b1;
            left_n = tap_r;
          end else begin
            open_n = open_r;
          end
          state_n = STEP;
        end else if (open_r) begin
          // Window closed: the last passing tap is one below.
          right_n = tap_r - 8'd1;
          cph_n   = CPH_CHECK;
          state_n = CENTER;
        end else begin
          state_n = STEP;
        end
      end
      STEP: begin
        if ((tap_r == TAP_LAST) || lane.DELAY_LINE_OUT_OF_RANGE) begin
          if (open_r) begin
            right_n = tap_r;
            cph_n   = CPH_CHECK;
            state_n = CENTER;
          end else begin
            state_n = ERR;
          end
        end else begin
          dir_n   = 1'b1;
          move_n  = 1'b1;
          tap_n   = tap_r + 8'd1;
          state_n = CLEAR;
        end
      end
      CENTER: begin
        case (cph_r)
          CPH_CHECK: begin
            if (eye_too_narrow(left_r, right_r, MIN_EYE)) begin
              state_n = ERR;
            end else begin
              // Drop direction a cycle ahead of the first downward move.
              target_n = center_tap(left_r, right_r);
              dir_n    = 1'b0;
              cph_n    = CPH_MOVE;
            end
          end
          CPH_MOVE: begin
            if (tap_r == target_r) begin
              fin_n   = 1'b1;
              state_n = SETTLE;
            end else begin
              move_n = 1'b1;
              tap_n  = tap_r - 8'd1;
              cph_n  = CPH_GAP;
            end
          end
          CPH_GAP: begin
            cph_n = CPH_MOVE;
          end
          default: begin
            cph_n = CPH_CHECK;
          end
        endcase
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    done_n = (state_n == DONE);
    err_n  = (state_n == ERR);
  end

  // State, datapath and registered output update.
  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_r  <= IDLE;
      cph_r    <= CPH_CHECK;
      tap_r    <= 8'd0;
      left_r   <= 8'd0;
      right_r  <= 8'd0;
      target_r <= 8'd0;
      open_r   <= 1'b0;
      pass_r   <= 1'b0;
      fin_r    <= 1'b0;
      load_r   <= 1'b0;
      move_r   <= 1'b0;
      clr_r    <= 1'b0;
      dir_r    <= 1'b0;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_n;
      cph_r    <= cph_n;
      tap_r    <= tap_n;
      left_r   <= left_n;
      right_r  <= right_n;
      target_r <= target_n;
      open_r   <= open_n;
      pass_r   <= pass_n;
      fin_r    <= fin_n;
      load_r   <= load_n;
      move_r   <= move_n;
      clr_r    <= clr_n;
      dir_r    <= dir_n;
      done_r   <= done_n;
      err_r    <= err_n;
    end
  end

  assign lane.DELAY_LINE_LOAD         = load_r;
  assign lane.DELAY_LINE_MOVE         = move_r;
  assign lane.DELAY_LINE_DIRECTION    = dir_r;
  assign lane.EYE_MONITOR_CLEAR_FLAGS = clr_r;
  assign TAP_COUNT                    = tap_r;
  assign TRAIN_DONE                   = done_r;
  assign TRAIN_ERR                    = err_r;

`ifdef DQS_TRAIN_STATUS_EN
  assign EYE_LEFT  = left_r;
  assign EYE_RIGHT = right_r;
`endif

endmodule

// File: tb/tb_ddr_dqs_eye_train.sv
// Self-checking bench for ddr_dqs_eye_train. A lane model (delay-line tap
// tracker plus sticky eye flags driven from a pass mask) responds to the DUT;
// expected results come from a tap-by-tap scan model of the training rules.
module tb_ddr_dqs_eye_train;

  logic       FAB_CLK = 1'b0;
  logic       ARST_N  = 1'b0;
  logic       TRAIN_START = 1'b0;
  logic [7:0] TAP_COUNT;
  logic       TRAIN_DONE;
  logic       TRAIN_ERR;
`ifdef DQS_TRAIN_STATUS_EN
  logic [7:0] EYE_LEFT;
  logic [7:0] EYE_RIGHT;
`endif

  ddr_dqs_eye_train_if lane ();

  ddr_dqs_eye_train dut (
    .FAB_CLK     (FAB_CLK),
    .ARST_N      (ARST_N),
    .TRAIN_START (TRAIN_START),
    .lane        (lane),
    .TAP_COUNT   (TAP_COUNT),
    .TRAIN_DONE  (TRAIN_DONE),
    .TRAIN_ERR   (TRAIN_ERR)
`ifdef DQS_TRAIN_STATUS_EN
    ,
    .EYE_LEFT    (EYE_LEFT),
    .EYE_RIGHT   (EYE_RIGHT)
`endif
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int checks = 0;
  int errors = 0;

  // Lane model state.
  logic [127:0] cur_mask = 128'd0;
  int           cur_oor  = 1000;
  int           tb_tap   = 0;
  logic         early_r  = 1'b0;
  logic         late_r   = 1'b0;
  int           load_cnt = 0;
  int           move_cnt = 0;
  int           clr_cnt  = 0;
  int           viol     = 0;
  logic         prev_load = 1'b0;
  logic         prev_move = 1'b0;
  logic         prev_clr  = 1'b0;
  logic         prev_dir  = 1'b0;
  logic         tap_fail;

  assign tap_fail = (tb_tap < 0 || tb_tap > 127) ? 1'b1 : ~cur_mask[tb_tap[6:0]];
  assign lane.EYE_MONITOR_EARLY       = early_r;
  assign lane.EYE_MONITOR_LATE        = late_r;
  assign lane.DELAY_LINE_OUT_OF_RANGE = (tb_tap >= cur_oor);

  // Lane model and protocol watch: tracks the delay line, sets sticky flags on
  // failing taps, and flags malformed LOAD/CLEAR/MOVE/DIRECTION sequences.
  always @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      tb_tap    <= 0;
      early_r   <= 1'b0;
      late_r    <= 1'b0;
      prev_load <= 1'b0;
      prev_move <= 1'b0;
      prev_clr  <= 1'b0;
      prev_dir  <= 1'b0;
    end else begin
      if (lane.DELAY_LINE_LOAD) tb_tap <= 0;
      else if (lane.DELAY_LINE_MOVE) tb_tap <= lane.DELAY_LINE_DIRECTION ? tb_tap + 1 : tb_tap - 1;
      if (lane.EYE_MONITOR_CLEAR_FLAGS) begin
        early_r <= 1'b0;
        late_r  <= 1'b0;
      end else if (tap_fail) begin
        if (tb_tap[0]) early_r <= 1'b1;
        else late_r <= 1'b1;
      end
      if (lane.DELAY_LINE_LOAD) load_cnt <= load_cnt + 1;
      if (lane.DELAY_LINE_MOVE) move_cnt <= move_cnt + 1;
      if (lane.EYE_MONITOR_CLEAR_FLAGS) clr_cnt <= clr_cnt + 1;
      if (lane.DELAY_LINE_LOAD && prev_load) begin
        $display("FAIL load_pulse_width: LOAD high on two consecutive cycles at %0t", $time);
        viol <= viol + 1;
      end
      if (lane.EYE_MONITOR_CLEAR_FLAGS && prev_clr) begin
        $display("FAIL clear_pulse_width: CLEAR_FLAGS high on two consecutive cycles at %0t", $time);
        viol <= viol + 1;
      end
      if (lane.DELAY_LINE_MOVE && prev_move) begin
        $display("FAIL move_back_to_back: MOVE high on two consecutive cycles at %0t", $time);
        viol <= viol + 1;
      end
      if (lane.DELAY_LINE_MOVE && (lane.DELAY_LINE_DIRECTION != prev_dir)) begin
        $display("FAIL dir_stable: DIRECTION %0b during MOVE, %0b the cycle before, at %0t",
                 lane.DELAY_LINE_DIRECTION, prev_dir, $time);
        viol <= viol + 1;
      end
      prev_load <= lane.DELAY_LINE_LOAD;
      prev_move <= lane.DELAY_LINE_MOVE;
      prev_clr  <= lane.EYE_MONITOR_CLEAR_FLAGS;
      prev_dir  <= lane.DELAY_LINE_DIRECTION;
    end
  end

  function automatic logic [127:0] make_mask(input int lo, input int hi);
    logic [127:0] m;
    m = 128'd0;
    for (int i = 0; i < 128; i++) if (i >= lo && i <= hi) m[i] = 1'b1;
    return m;
  endfunction

  // Scan model: walk taps upward applying the window rules, then centre.
  task automatic ref_model(input logic [127:0] mask, input int oor,
                           output bit exp_done, output int exp_tap,
                           output bit exp_open, output int exp_l, output int exp_r);
    bit open;
    int l;
    int r;
    int t;
    bit ended;
    open = 0; l = 0; r = 0; ended = 0; exp_done = 0; exp_tap = 0;
    for (t = 0; t <= 127 && !ended; t++) begin
      if (mask[t] && !open) begin
        open = 1;
        l = t;
      end else if (!mask[t] && open) begin
        r = t - 1;
        ended = 1;
      end
      if (!ended && (t == 127 || t >= oor)) begin
        if (open) r = t;
        ended = 1;
      end
      if (ended) exp_tap = t;
    end
    exp_open = open;
    exp_l = l;
    exp_r = r;
    if (open && (r - l + 1) >= 4) begin
      exp_done = 1;
      exp_tap = (l + r) / 2;
    end
  endtask

  task automatic run_train(input logic [127:0] mask, input int oor,
                           input string name, input bit poke_in_sample);
    bit  exp_done;
    bit  exp_open;
    int  exp_tap;
    int  exp_l;
    int  exp_r;
    int  load0;
    int  viol0;
    bit  seen;
    cur_mask = mask;
    cur_oor  = oor;
    ref_model(mask, oor, exp_done, exp_tap, exp_open, exp_l, exp_r);
    load0 = load_cnt;
    viol0 = viol;
    @(posedge FAB_CLK); #1;
    TRAIN_START = 1'b1;
    @(posedge FAB_CLK); #1;
    TRAIN_START = 1'b0;
    checks++;
    if (lane.DELAY_LINE_LOAD !== 1'b1 || TAP_COUNT !== 8'd0) begin
      $display("FAIL %s_load: LOAD=%0b TAP=%0d, want LOAD=1 TAP=0", name, lane.DELAY_LINE_LOAD, TAP_COUNT);
      errors++;
    end
    checks++;
    if (TRAIN_DONE !== 1'b0 || TRAIN_ERR !== 1'b0) begin
      $display("FAIL %s_status_clear: DONE=%0b ERR=%0b, want 0 0", name, TRAIN_DONE, TRAIN_ERR);
      errors++;
    end
    if (poke_in_sample) begin
      seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(posedge FAB_CLK); #1;
        if (lane.EYE_MONITOR_CLEAR_FLAGS === 1'b1) seen = 1;
      end
      repeat (12) @(posedge FAB_CLK);
      #1 TRAIN_START = 1'b1;
      @(posedge FAB_CLK); #1;
      TRAIN_START = 1'b0;
    end
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(posedge FAB_CLK); #1;
      if (TRAIN_DONE === 1'b1 || TRAIN_ERR === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL %s_timeout: no DONE/ERR within 20000 cycles", name);
      errors++;
    end
    repeat (5) @(posedge FAB_CLK);
    #1;
    checks++;
    if (TRAIN_DONE !== exp_done || TRAIN_ERR !== !exp_done) begin
      $display("FAIL %s_result: DONE=%0b ERR=%0b, want DONE=%0b ERR=%0b",
               name, TRAIN_DONE, TRAIN_ERR, exp_done, !exp_done);
      errors++;
    end
    checks++;
    if (TAP_COUNT !== 8'(exp_tap)) begin
      $display("FAIL %s_tap: TAP_COUNT=%0d, want %0d", name, TAP_COUNT, exp_tap);
      errors++;
    end
    checks++;
    if (tb_tap !== exp_tap) begin
      $display("FAIL %s_delay_line: lane tap=%0d, want %0d", name, tb_tap, exp_tap);
      errors++;
    end
    checks++;
    if (load_cnt - load0 !== 1) begin
      $display("FAIL %s_load_count: %0d LOAD pulses, want 1", name, load_cnt - load0);
      errors++;
    end
    checks++;
    if (viol !== viol0) begin
      $display("FAIL %s_protocol: %0d protocol violations, want 0", name, viol - viol0);
      errors++;
    end
`ifdef DQS_TRAIN_STATUS_EN
    if (exp_open) begin
      checks++;
      if (EYE_LEFT !== 8'(exp_l) || EYE_RIGHT !== 8'(exp_r)) begin
        $display("FAIL %s_edges: LEFT=%0d RIGHT=%0d, want %0d %0d", name, EYE_LEFT, EYE_RIGHT, exp_l, exp_r);
        errors++;
      end
    end
`endif
  endtask

  task automatic test_reset();
    int l0, m0, c0;
    ARST_N = 1'b0;
    #1;
    checks++;
    if ({TAP_COUNT, TRAIN_DONE, TRAIN_ERR, lane.DELAY_LINE_LOAD, lane.DELAY_LINE_MOVE,
         lane.DELAY_LINE_DIRECTION, lane.EYE_MONITOR_CLEAR_FLAGS} !== 14'd0) begin
      $display("FAIL reset_outputs: TAP=%0d DONE=%0b ERR=%0b, want all 0", TAP_COUNT, TRAIN_DONE, TRAIN_ERR);
      errors++;
    end
    repeat (3) @(posedge FAB_CLK);
    #2 ARST_N = 1'b1;
    l0 = load_cnt; m0 = move_cnt; c0 = clr_cnt;
    repeat (40) @(posedge FAB_CLK);
    #1;
    checks++;
    if (load_cnt != l0 || move_cnt != m0 || clr_cnt != c0 || TAP_COUNT !== 8'd0) begin
      $display("FAIL reset_quiet: load=%0d move=%0d clr=%0d tap=%0d, want 0 0 0 0",
               load_cnt - l0, move_cnt - m0, clr_cnt - c0, TAP_COUNT);
      errors++;
    end
  endtask

  task automatic test_basic_eye();
    run_train(make_mask(20, 59), 1000, "basic_eye", 1'b0);
  endtask

  task automatic test_flags_always();
    run_train(128'd0, 1000, "flags_always", 1'b0);
  endtask

  task automatic test_narrow_eye();
    run_train(make_mask(10, 12), 1000, "narrow_eye", 1'b0);
  endtask

  task automatic test_out_of_range();
    run_train(make_mask(100, 127), 110, "out_of_range", 1'b0);
  endtask

  task automatic test_two_windows();
    run_train(make_mask(20, 29) | make_mask(40, 59), 1000, "two_windows", 1'b0);
  endtask

  task automatic test_all_pass();
    run_train(make_mask(0, 127), 1000, "all_pass", 1'b0);
  endtask

  task automatic test_start_in_sample();
    run_train(make_mask(20, 59), 1000, "start_in_sample", 1'b1);
  endtask

  task automatic test_reset_in_center();
    bit seen;
    int l0, m0, c0;
    cur_mask = make_mask(20, 59);
    cur_oor  = 1000;
    @(posedge FAB_CLK); #1;
    TRAIN_START = 1'b1;
    @(posedge FAB_CLK); #1;
    TRAIN_START = 1'b0;
    seen = 0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(posedge FAB_CLK); #1;
      if (lane.DELAY_LINE_MOVE === 1'b1 && lane.DELAY_LINE_DIRECTION === 1'b0) seen = 1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL center_reach: no downward MOVE within 20000 cycles");
      errors++;
    end
    #2 ARST_N = 1'b0;
    #1;
    checks++;
    if ({TAP_COUNT, TRAIN_DONE, TRAIN_ERR, lane.DELAY_LINE_LOAD, lane.DELAY_LINE_MOVE,
         lane.DELAY_LINE_DIRECTION, lane.EYE_MONITOR_CLEAR_FLAGS} !== 14'd0) begin
      $display("FAIL center_reset_outputs: TAP=%0d MOVE=%0b DIR=%0b DONE=%0b, want all 0",
               TAP_COUNT, lane.DELAY_LINE_MOVE, lane.DELAY_LINE_DIRECTION, TRAIN_DONE);
      errors++;
    end
    #3 ARST_N = 1'b1;
    l0 = load_cnt; m0 = move_cnt; c0 = clr_cnt;
    repeat (40) @(posedge FAB_CLK);
    #1;
    checks++;
    if (load_cnt != l0 || move_cnt != m0 || clr_cnt != c0 || TAP_COUNT !== 8'd0 ||
        TRAIN_DONE !== 1'b0 || TRAIN_ERR !== 1'b0) begin
      $display("FAIL center_reset_idle: load=%0d move=%0d clr=%0d tap=%0d, want quiet idle",
               load_cnt - l0, move_cnt - m0, clr_cnt - c0, TAP_COUNT);
      errors++;
    end
  endtask

  task automatic test_random();
    int lo;
    int w;
    int oor;
    for (int k = 0; k < 4; k++) begin
      lo  = $urandom_range(0, 110);
      w   = $urandom_range(1, 25);
      oor = ($urandom_range(0, 1) == 0) ? 1000 : $urandom_range(0, 127);
      run_train(make_mask(lo, lo + w - 1), oor, $sformatf("random%0d", k), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_eye();
    test_flags_always();
    test_narrow_eye();
    test_out_of_range();
    test_two_windows();
    test_all_pass();
    test_start_in_sample();
    test_reset_in_center();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
